// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : Adds two 4*NIBBLES-bit operands one nibble per clock by
//               sequencing an external 4-bit fullAdder (start/busy/done).
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   opA,
    input  logic [4*NIBBLES-1:0]   opB,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic [3:0]             fa_a,
    output logic [3:0]             fa_b,
    output logic                   fa_cIn,
    input  logic [3:0]             fa_sum,
    input  logic                   fa_cOut
);

    localparam int c_W     = 4 * NIBBLES;
    localparam int c_IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NIBBLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_carry;
    logic [c_W-1:0]       r_a;
    logic [c_W-1:0]       r_b;
    logic [c_W-1:0]       r_result;
    logic                 r_cout;
    logic                 w_run;
    logic                 w_last;
    logic [c_IDX_W+1:0]   w_lsb;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_run  = (r_state == S_RUN);
    assign w_last = (r_idx == c_LAST_IDX);
    assign w_lsb  = {r_idx, 2'b00};

    // The fullAdder sits outside; its inputs are forced to zero when idle.
    assign fa_a   = w_run ? r_a[w_lsb +: 4] : 4'd0;
    assign fa_b   = w_run ? r_b[w_lsb +: 4] : 4'd0;
    assign fa_cIn = w_run ? r_carry : 1'b0;

    assign busy   = (r_state == S_RUN) || (r_state == S_DONE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign cout   = r_cout;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= opA;
                        r_b     <= opB;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    // Upper nibbles keep stale data until this slice reaches them.
                    r_result[w_lsb +: 4] <= fa_sum;
                    r_carry              <= fa_cOut;
                    if (w_last) begin
                        r_cout <= fa_cOut;
                        r_idx  <= '0;
                    end else begin
                        r_idx  <= r_idx + c_IDX_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
